pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register that generalises the fixed IF/ID buffer into a reusable inter-stage block for any stage boundary of the MiniRiscV pipeline. It carries a held lane (control + data, obeying stall/flush with a valid/ready handshake and optional 2-entry skid storage) and a pass lane (always advances, reset-only). It also keeps saturating stall and flush counters for hazard-unit debug. All state updates on the falling edge of `clk`, as for the other pipeline buffers.

---
 rtl/pipe_stage_buf.sv | 156 +++++++++++++++
 tb/tb_pipe_stage_buf.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage pipeline register with a held lane (valid/ready, stall/flush,
// optional 2-entry skid), an unconditional pass lane and saturating stall/flush counters.
`default_nettype none

module pipe_stage_buf #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32,
  parameter int PASS_W = 38,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [DATA_W-1:0] up_data,
  output logic              down_valid,
  input  logic              down_ready,
  output logic [CTRL_W-1:0] down_ctrl,
  output logic [DATA_W-1:0] down_data,
  input  logic              stall,
  input  logic              clear,
  input  logic [PASS_W-1:0] pass_i,
  output logic [PASS_W-1:0] pass_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q;
  logic [CTRL_W-1:0] s_ctrl_q;
  logic [DATA_W-1:0] s_data_q;
  logic [PASS_W-1:0] pass_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic in_fire;
  logic out_fire;
  logic m_load;

  assign in_fire  = up_valid & up_ready;
  assign out_fire = m_valid_q & down_ready & ~stall;
  assign m_load   = out_fire | ~m_valid_q;

  // M refills from S first so the skid entry always leaves before a newer beat.
  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    if (clear) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end else if (m_load) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = s_ctrl_q;
        m_data_d  = s_data_q;
      end else if (in_fire) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = up_ctrl;
        m_data_d  = up_data;
      end else begin
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!clear && m_valid_q && (stall || !down_ready) && stall_cnt_q != C_CNT_MAX)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (clear && (m_valid_q || s_valid_q || in_fire) && flush_cnt_q != C_CNT_MAX)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q   <= 1'b0;
      m_ctrl_q    <= '0;
      m_data_q    <= '0;
      pass_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_ctrl_q    <= m_ctrl_d;
      m_data_q    <= m_data_d;
      pass_q      <= pass_i;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic              s_valid_d;
      logic [CTRL_W-1:0] s_ctrl_d;
      logic [DATA_W-1:0] s_data_d;
      logic              s_take;

      assign s_take = in_fire & m_valid_q & ~out_fire;

      always_comb begin
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;
        if (clear) begin
          s_valid_d = 1'b0;
        end else if (s_take) begin
          s_valid_d = 1'b1;
          s_ctrl_d  = up_ctrl;
          s_data_d  = up_data;
        end else if (s_valid_q && m_load) begin
          s_valid_d = 1'b0;
        end
      end

      always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
          s_valid_q <= 1'b0;
          s_ctrl_q  <= '0;
          s_data_q  <= '0;
        end else begin
          s_valid_q <= s_valid_d;
          s_ctrl_q  <= s_ctrl_d;
          s_data_q  <= s_data_d;
        end
      end

      // Taken straight from a flop: no path from down_ready/stall to up_ready.
      assign up_ready = ~s_valid_q;
    end else begin : g_single
      assign s_valid_q = 1'b0;
      assign s_ctrl_q  = '0;
      assign s_data_q  = '0;
      assign up_ready  = ~m_valid_q | out_fire;
    end
  endgenerate

  assign down_valid = m_valid_q;
  assign down_ctrl  = m_ctrl_q;
  assign down_data  = m_data_q;
  assign pass_o     = pass_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a skid instance (4-bit counters) and a single-entry instance
// run side by side against a FIFO-level reference model.
`default_nettype none

module tb_pipe_stage_buf;

  logic        clk;
  logic        rst;
  logic        up_valid;
  logic [7:0]  up_ctrl;
  logic [31:0] up_data;
  logic        down_ready;
  logic        stall;
  logic        clear;
  logic [37:0] pass_i;

  logic        ur [2];
  logic        dv [2];
  logic [7:0]  dc [2];
  logic [31:0] dd [2];
  logic [37:0] po [2];
  logic [15:0] sc [2];
  logic [15:0] fc [2];
  logic [3:0]  sc4;
  logic [3:0]  fc4;

  assign sc[0] = {12'd0, sc4};
  assign fc[0] = {12'd0, fc4};

  pipe_stage_buf #(.CTRL_W(8), .DATA_W(32), .PASS_W(38), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(ur[0]),
    .up_ctrl(up_ctrl), .up_data(up_data), .down_valid(dv[0]), .down_ready(down_ready),
    .down_ctrl(dc[0]), .down_data(dd[0]), .stall(stall), .clear(clear),
    .pass_i(pass_i), .pass_o(po[0]), .stall_cnt(sc4), .flush_cnt(fc4));

  pipe_stage_buf #(.CTRL_W(8), .DATA_W(32), .PASS_W(38), .SKID(0), .CNT_W(16)) u_single (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(ur[1]),
    .up_ctrl(up_ctrl), .up_data(up_data), .down_valid(dv[1]), .down_ready(down_ready),
    .down_ctrl(dc[1]), .down_data(dd[1]), .stall(stall), .clear(clear),
    .pass_i(pass_i), .pass_o(po[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each instance is a FIFO of capacity 2 (skid) or 1 (single).
  logic [39:0] fifo  [2][2];
  int          cnt   [2];
  int          cap   [2] = '{2, 1};
  int          cmax  [2] = '{15, 65535};
  int          scnt  [2];
  int          fcnt  [2];
  logic [31:0] mdata [2];
  logic [37:0] mpass;
  string       nm    [2] = '{"skid", "single"};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ready(input int i);
    if (cap[i] == 2) return cnt[i] < 2;
    return (cnt[i] == 0) || (down_ready && !stall);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; scnt[i] = 0; fcnt[i] = 0; mdata[i] = '0;
    end
    mpass = '0;
  endtask

  task automatic model_edge(input int i, input logic inf);
    logic outf;
    outf = (cnt[i] > 0) && down_ready && !stall;
    if (clear) begin
      if ((cnt[i] > 0 || inf) && fcnt[i] < cmax[i]) fcnt[i]++;
      cnt[i] = 0;
    end else begin
      if (cnt[i] > 0 && (stall || !down_ready) && scnt[i] < cmax[i]) scnt[i]++;
      if (outf) begin
        fifo[i][0] = fifo[i][1];
        cnt[i]--;
      end
      if (inf) begin
        fifo[i][cnt[i]] = {up_ctrl, up_data};
        cnt[i]++;
      end
    end
    if (cnt[i] > 0) mdata[i] = fifo[i][0][31:0];
  endtask

  task automatic check_all();
    logic [39:0] head;
    for (int i = 0; i < 2; i++) begin
      head = fifo[i][0];
      chk({nm[i], ".down_valid"}, 64'(dv[i]), 64'(cnt[i] > 0));
      chk({nm[i], ".down_ctrl"},  64'(dc[i]), (cnt[i] > 0) ? 64'(head[39:32]) : 64'd0);
      chk({nm[i], ".down_data"},  64'(dd[i]), (cnt[i] > 0) ? 64'(head[31:0]) : 64'(mdata[i]));
      chk({nm[i], ".pass_o"},     64'(po[i]), 64'(mpass));
      chk({nm[i], ".stall_cnt"},  64'(sc[i]), 64'(scnt[i]));
      chk({nm[i], ".flush_cnt"},  64'(fc[i]), 64'(fcnt[i]));
      chk({nm[i], ".up_ready"},   64'(ur[i]), 64'(m_ready(i)));
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] c, input logic [31:0] d,
                       input logic dr, input logic st, input logic cl, input logic [37:0] p);
    logic inf [2];
    up_valid = v; up_ctrl = c; up_data = d;
    down_ready = dr; stall = st; clear = cl; pass_i = p;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk({nm[i], ".up_ready_pre"}, 64'(ur[i]), 64'(m_ready(i)));
      inf[i] = v & m_ready(i);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, inf[i]);
    mpass = p;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; up_valid = 0; up_ctrl = 0; up_data = 0;
    down_ready = 0; stall = 0; clear = 0; pass_i = 0;
    #3;
    model_reset();
    check_all();
    @(negedge clk);
    #2 rst = 1'b1;

    // Streaming at full rate.
    for (int k = 1; k <= 4; k++)
      cycle(1, 8'(k), 32'(k * 8'h11), 1, 0, 0, 38'(k));
    cycle(0, 0, 0, 1, 0, 0, 0);

    // Backpressure: downstream stops after the 0x22 beat.
    cycle(1, 8'h01, 32'h11, 1, 0, 0, 0);
    cycle(1, 8'h02, 32'h22, 1, 0, 0, 0);
    cycle(1, 8'h03, 32'h33, 0, 0, 0, 0);
    cycle(1, 8'h04, 32'h44, 0, 0, 0, 0);
    cycle(1, 8'h04, 32'h44, 0, 0, 0, 0);
    cycle(1, 8'h04, 32'h44, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);

    // Fill then flush.
    cycle(1, 8'hA1, 32'hAAAA0001, 0, 0, 0, 0);
    cycle(1, 8'hA2, 32'hAAAA0002, 0, 0, 0, 0);
    cycle(1, 8'hA3, 32'hAAAA0003, 0, 0, 1, 38'h5A);
    chk("flush.down_valid", 64'(dv[0]), 64'd0);
    chk("flush.pass_o", 64'(po[0]), 64'h5A);

    // Stall and clear together, then single-entry pass-through ready.
    cycle(1, 8'hB1, 32'hBBBB0001, 1, 0, 0, 0);
    cycle(1, 8'hB2, 32'hBBBB0002, 1, 1, 1, 0);
    cycle(1, 8'hC1, 32'hCCCC0001, 1, 0, 0, 0);
    cycle(1, 8'hC2, 32'hCCCC0002, 1, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [37:0] p;
      p = {6'($urandom), 32'($urandom)};
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 32'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 19) == 0, p);
    end

    // Reset in the middle of traffic.
    cycle(1, 8'hD1, 32'hDDDD0001, 0, 0, 0, 38'h3FF);
    cycle(1, 8'hD2, 32'hDDDD0002, 0, 0, 0, 38'h3FE);
    do_reset();

    // Counter saturation with a stalled beat.
    cycle(1, 8'hE1, 32'hEEEE0001, 1, 1, 0, 0);
    for (int n = 0; n < 20; n++) cycle(0, 0, 0, 1, 1, 0, 0);
    chk("sat.stall_cnt", 64'(sc4), 64'd15);
    cycle(0, 0, 0, 1, 1, 0, 0);
    chk("sat.stall_hold", 64'(sc4), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
